// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and types for the register file slice.
//   DEF_DATA_W / DEF_ADDR_W : default word width and index width
//   REG_ZERO                : index of the hardwired-zero register
//   reg_idx_t / word_t      : index and word types at the default widths
package regfile_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int REG_ZERO   = 0;

  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
  typedef logic [DEF_DATA_W-1:0] word_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: one pending-write (busy) bit per register.
//   clk, rst            : clock, asynchronous active-high reset
//   ra, rb              : read indices whose busy status is reported
//   rd, reg_write       : writeback index / enable, clears the busy bit
//   issue_valid, issue_rd : issuing instruction's destination, sets the busy bit
//   busy_a, busy_b      : pending-write status for ra / rb (writeback this cycle hides it)
//   sb_err              : sticky flag, issue to a register that is still busy
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  input  logic [ADDR_W-1:0] rd,
  input  logic              reg_write,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              busy_a,
  output logic              busy_b,
  output logic              sb_err
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_next;
  logic             r_sb_err;
  logic             w_set_ok;
  logic             w_clr_ok;
  logic             w_waw;

  // The zero register never tracks a producer.
  assign w_set_ok = issue_valid && !(ZERO_REG && (issue_rd == ADDR_W'(REG_ZERO)));
  assign w_clr_ok = reg_write   && !(ZERO_REG && (rd       == ADDR_W'(REG_ZERO)));

  // Set has priority over clear: a new producer replaces the retiring one.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_busy
      assign w_busy_next[gi] = (w_set_ok && (issue_rd == ADDR_W'(gi))) ? 1'b1 :
                               (w_clr_ok && (rd       == ADDR_W'(gi))) ? 1'b0 :
                               r_busy[gi];
    end
  endgenerate

  // A register being retired in the same cycle is no longer an outstanding producer.
  assign w_waw = w_set_ok && r_busy[issue_rd] && !(w_clr_ok && (rd == issue_rd));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy   <= '0;
      r_sb_err <= 1'b0;
    end else begin
      r_busy <= w_busy_next;
      if (w_waw) r_sb_err <= 1'b1;
    end
  end

  // The writeback in flight this cycle already satisfies the reader.
  assign busy_a = r_busy[ra] && !(reg_write && (rd == ra));
  assign busy_b = r_busy[rb] && !(reg_write && (rd == rb));
  assign sb_err = r_sb_err;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: register file with two combinational read ports, one write port
// with same-cycle write-to-read bypass, optional hardwired-zero r0, and an
// integrated pending-write scoreboard.
//   clk, rst        : clock, asynchronous active-high reset (clears words, busy, sb_err)
//   Ra, Rb          : read indices;  out_a, out_b : read data
//   busy_a, busy_b  : pending-write status of Ra / Rb
//   Rd, RegWrite, Data : writeback port (also clears the busy bit)
//   IssueValid, IssueRd : issuing instruction's destination (sets the busy bit)
//   sb_err          : sticky, issue to an already-busy register
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Ra,
  input  logic [ADDR_W-1:0] Rb,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              busy_a,
  output logic              busy_b,
  input  logic [ADDR_W-1:0] Rd,
  input  logic              RegWrite,
  input  logic [DATA_W-1:0] Data,
  input  logic              IssueValid,
  input  logic [ADDR_W-1:0] IssueRd,
  output logic              sb_err
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_we;

  assign w_we = RegWrite && !(ZERO_REG && (Rd == ADDR_W'(REG_ZERO)));

  // Storage is reset as a whole, so it lives in flops rather than block RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_we) begin
      r_mem[Rd] <= Data;
    end
  end

  // Bypass is checked after the zero test so a write to r0 never leaks through.
  always_comb begin
    out_a = r_mem[Ra];
    if (ZERO_REG && (Ra == ADDR_W'(REG_ZERO))) out_a = '0;
    else if (RegWrite && (Rd == Ra))           out_a = Data;
  end

  always_comb begin
    out_b = r_mem[Rb];
    if (ZERO_REG && (Rb == ADDR_W'(REG_ZERO))) out_b = '0;
    else if (RegWrite && (Rd == Rb))           out_b = Data;
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .ra          (Ra),
    .rb          (Rb),
    .rd          (Rd),
    .reg_write   (RegWrite),
    .issue_valid (IssueValid),
    .issue_rd    (IssueRd),
    .busy_a      (busy_a),
    .busy_b      (busy_b),
    .sb_err      (sb_err)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: drives two register files from one stimulus stream -- the
// default 32x32 with hardwired r0, and a 16x64 variant without the zero
// register -- and checks both against an array-based reference model.
module tb_regfile_sb;
  logic        clk;
  logic        rst;
  logic        RegWrite;
  logic        IssueValid;
  logic [4:0]  Ra1, Rb1, Rd1, Ird1;
  logic [3:0]  Ra2, Rb2, Rd2, Ird2;
  logic [31:0] Data1;
  logic [63:0] Data2;
  logic [31:0] out_a1, out_b1;
  logic [63:0] out_a2, out_b2;
  logic        busy_a1, busy_b1, err1;
  logic        busy_a2, busy_b2, err2;

  regfile_sb u_dut32 (
    .clk(clk), .rst(rst), .Ra(Ra1), .Rb(Rb1), .out_a(out_a1), .out_b(out_b1),
    .busy_a(busy_a1), .busy_b(busy_b1), .Rd(Rd1), .RegWrite(RegWrite), .Data(Data1),
    .IssueValid(IssueValid), .IssueRd(Ird1), .sb_err(err1)
  );

  regfile_sb #(.DATA_W(64), .ADDR_W(4), .ZERO_REG(1'b0)) u_dut64 (
    .clk(clk), .rst(rst), .Ra(Ra2), .Rb(Rb2), .out_a(out_a2), .out_b(out_b2),
    .busy_a(busy_a2), .busy_b(busy_b2), .Rd(Rd2), .RegWrite(RegWrite), .Data(Data2),
    .IssueValid(IssueValid), .IssueRd(Ird2), .sb_err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: index 0 = 32-bit/zero-reg DUT, index 1 = 64-bit/no-zero DUT.
  logic [63:0] m_mem  [2][32];
  bit          m_busy [2][32];
  bit          m_err  [2];
  bit          zr     [2] = '{1'b1, 1'b0};
  int          amask  [2] = '{31, 15};
  logic [63:0] dmask  [2] = '{64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};

  int n_cmp = 0;
  int n_mis = 0;
  int n_cyc = 0;

  // Snapshots of the outputs taken at the last check point.
  logic [63:0] s_a [2];
  logic [63:0] s_b [2];
  bit          s_ba [2];
  bit          s_bb [2];
  bit          s_err [2];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    for (int k = 0; k < 2; k++) begin
      m_err[k] = 1'b0;
      for (int i = 0; i < 32; i++) begin
        m_mem[k][i]  = '0;
        m_busy[k][i] = 1'b0;
      end
    end
  endfunction

  function automatic logic [63:0] m_read(int k, int a, bit we, int rd, logic [63:0] d);
    if (zr[k] && a == 0) return '0;
    if (we && rd == a)   return d;
    return m_mem[k][a];
  endfunction

  function automatic bit m_busy_of(int k, int a, bit we, int rd);
    if (zr[k] && a == 0) return 1'b0;
    return m_busy[k][a] && !(we && rd == a);
  endfunction

  function automatic void m_edge(int k, bit we, int rd, logic [63:0] d, bit iv, int ird);
    bit do_wr  = we && !(zr[k] && rd == 0);
    bit do_iss = iv && !(zr[k] && ird == 0);
    if (rst) return;
    if (do_iss && m_busy[k][ird] && !(do_wr && rd == ird)) m_err[k] = 1'b1;
    if (do_wr) begin
      m_mem[k][rd]  = d;
      m_busy[k][rd] = 1'b0;
    end
    if (do_iss) m_busy[k][ird] = 1'b1;
  endfunction

  task automatic check_outputs(input bit we, input int rd, input logic [63:0] d, input int ra, input int rb);
    s_a[0] = 64'(out_a1); s_b[0] = 64'(out_b1); s_ba[0] = busy_a1; s_bb[0] = busy_b1; s_err[0] = err1;
    s_a[1] = out_a2;      s_b[1] = out_b2;      s_ba[1] = busy_a2; s_bb[1] = busy_b2; s_err[1] = err2;
    for (int k = 0; k < 2; k++) begin
      int a  = ra & amask[k];
      int b  = rb & amask[k];
      int w  = rd & amask[k];
      logic [63:0] dk = d & dmask[k];
      check_eq($sformatf("out_a[%0d] ra=%0d", k, a), s_a[k], m_read(k, a, we, w, dk));
      check_eq($sformatf("out_b[%0d] rb=%0d", k, b), s_b[k], m_read(k, b, we, w, dk));
      check_eq($sformatf("busy_a[%0d] ra=%0d", k, a), 64'(s_ba[k]), 64'(m_busy_of(k, a, we, w)));
      check_eq($sformatf("busy_b[%0d] rb=%0d", k, b), 64'(s_bb[k]), 64'(m_busy_of(k, b, we, w)));
      check_eq($sformatf("sb_err[%0d]", k), 64'(s_err[k]), 64'(m_err[k]));
    end
  endtask

  // One clock cycle: drive at edge+1, check before the edge, advance the model at the edge.
  task automatic do_cycle(input bit we, input int rd, input logic [63:0] d,
                          input bit iv, input int ird, input int ra, input int rb);
    RegWrite = we; IssueValid = iv;
    Rd1 = 5'(rd); Ird1 = 5'(ird); Ra1 = 5'(ra); Rb1 = 5'(rb); Data1 = d[31:0];
    Rd2 = 4'(rd); Ird2 = 4'(ird); Ra2 = 4'(ra); Rb2 = 4'(rb); Data2 = d;
    #2;
    check_outputs(we, rd, d, ra, rb);
    @(posedge clk);
    for (int k = 0; k < 2; k++)
      m_edge(k, we, rd & amask[k], d & dmask[k], iv, ird & amask[k]);
    #1;
    n_cyc++;
    $display("cyc %0d rst=%0b we=%0b rd=%0d d=%h iv=%0b ird=%0d ra=%0d rb=%0d a32=%h b32=%h a64=%h b64=%h err=%0b%0b",
             n_cyc, rst, we, rd, d, iv, ird, ra, rb, s_a[0][31:0], s_b[0][31:0], s_a[1], s_b[1], s_err[0], s_err[1]);
  endtask

  // Assert reset between edges; outputs must clear before the next edge. rst is left high.
  task automatic async_reset(input int ra, input int rb);
    RegWrite = 1'b0; IssueValid = 1'b0;
    Ra1 = 5'(ra); Rb1 = 5'(rb); Ra2 = 4'(ra); Rb2 = 4'(rb);
    #2;
    rst = 1'b1;
    #1;
    m_reset();
    check_outputs(1'b0, 0, 64'd0, ra, rb);
    $display("async reset ra=%0d rb=%0d a32=%h a64=%h err=%0b%0b", ra, rb, s_a[0][31:0], s_a[1], s_err[0], s_err[1]);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; RegWrite = 1'b0; IssueValid = 1'b0;
    Ra1 = '0; Rb1 = '0; Rd1 = '0; Ird1 = '0; Data1 = '0;
    Ra2 = '0; Rb2 = '0; Rd2 = '0; Ird2 = '0; Data2 = '0;
    m_reset();
    #2;
    check_outputs(1'b0, 0, 64'd0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic writes and reads
    do_cycle(1, 1, 64'h1234, 0, 0, 0, 0);
    do_cycle(1, 2, 64'h2345, 0, 0, 0, 0);
    do_cycle(0, 0, 64'h0,    0, 0, 1, 2);
    check_eq("read r1", s_a[0], 64'h1234);
    check_eq("read r2", s_b[0], 64'h2345);
    check_eq("read r1 w64", s_a[1], 64'h1234);

    // Bypass, then hold after the write retires
    do_cycle(1, 3, 64'h3456, 0, 0, 3, 3);
    check_eq("bypass a", s_a[0], 64'h3456);
    check_eq("bypass b", s_b[0], 64'h3456);
    do_cycle(0, 3, 64'h5678, 0, 0, 3, 0);
    check_eq("after bypass", s_a[0], 64'h3456);

    // Zero register
    do_cycle(1, 0, 64'hFFFF_FFFF, 1, 0, 0, 0);
    check_eq("r0 write cycle", s_a[0], 64'h0);
    do_cycle(0, 0, 64'h0, 0, 0, 0, 0);
    check_eq("r0 after", s_a[0], 64'h0);
    check_eq("r0 never busy", 64'(s_ba[0]), 64'h0);
    check_eq("r0 stores w/o zero", s_a[1], 64'hFFFF_FFFF);
    check_eq("r0 busy w/o zero", 64'(s_ba[1]), 64'h1);

    // Scoreboard set / clear
    do_cycle(1, 0, 64'h0, 1, 5, 0, 0);
    do_cycle(0, 0, 64'h0, 0, 0, 5, 5);
    check_eq("busy r5", 64'(s_ba[0]), 64'h1);
    do_cycle(1, 5, 64'h6789, 0, 0, 5, 0);
    check_eq("clear hides busy", 64'(s_ba[0]), 64'h0);
    check_eq("clear bypass", s_a[0], 64'h6789);
    do_cycle(0, 0, 64'h0, 0, 0, 5, 0);
    check_eq("busy r5 after", 64'(s_ba[0]), 64'h0);

    // Simultaneous set/clear, then WAW
    do_cycle(0, 0, 64'h0, 1, 6, 0, 0);
    do_cycle(1, 6, 64'h7777, 1, 6, 0, 0);
    do_cycle(0, 0, 64'h0, 0, 0, 6, 0);
    check_eq("set wins", 64'(s_ba[0]), 64'h1);
    check_eq("no err", 64'(s_err[0]), 64'h0);
    do_cycle(0, 0, 64'h0, 1, 6, 0, 0);
    do_cycle(0, 0, 64'h0, 0, 0, 6, 0);
    check_eq("waw err", 64'(s_err[0]), 64'h1);
    check_eq("waw still busy", 64'(s_ba[0]), 64'h1);
    do_cycle(1, 6, 64'h1, 0, 0, 0, 0);
    do_cycle(0, 0, 64'h0, 0, 0, 0, 0);
    check_eq("err sticky", 64'(s_err[0]), 64'h1);

    // Async reset mid-stream
    do_cycle(1, 4, 64'h4444, 1, 7, 0, 0);
    do_cycle(0, 0, 64'h0, 0, 0, 7, 4);
    check_eq("r7 busy pre-reset", 64'(s_ba[0]), 64'h1);
    async_reset(7, 4);
    check_eq("rst out_b", s_b[0], 64'h0);
    check_eq("rst busy_a", 64'(s_ba[0]), 64'h0);
    check_eq("rst err", 64'(s_err[0]), 64'h0);
    do_cycle(1, 1, 64'hABCD, 1, 2, 1, 2);
    check_eq("bypass in reset", s_a[0], 64'hABCD);
    rst = 1'b0;
    do_cycle(0, 0, 64'h0, 0, 0, 1, 2);
    check_eq("write ignored in reset", s_a[0], 64'h0);
    check_eq("issue ignored in reset", 64'(s_bb[0]), 64'h0);

    // Randomised traffic, concentrated on a few registers to provoke hazards
    for (int t = 0; t < 400; t++) begin
      int ra, rb, rd, ird;
      ra  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
      rb  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
      rd  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
      ird = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
      if ($urandom_range(0, 59) == 0) begin
        async_reset(ra, rb);
        do_cycle($urandom_range(0, 1) == 1, rd, {$urandom, $urandom}, 1'b1, ird, ra, rb);
        rst = 1'b0;
      end else begin
        do_cycle($urandom_range(0, 1) == 1, rd, {$urandom, $urandom},
                 $urandom_range(0, 9) < 4, ird, ra, rb);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
